// File: rtl/vgacon_pkg.sv
// Shared constants and clear-FSM state type for the VGA console buffer arbiter.
package vgacon_pkg;

  localparam int         VGACON_DEPTH  = 96;
  localparam int         VGACON_ADDR_W = 7;
  localparam logic [7:0] VGACON_FILL   = 8'h20;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/vgacon_buffer_arbiter_if.sv
// CPU write port, video read port, clear control and single-port buffer bus.
interface vgacon_buffer_arbiter_if;
  import vgacon_pkg::*;

  logic                     cpu_wr_valid;
  logic [VGACON_ADDR_W-1:0] cpu_wr_addr;
  logic [7:0]               cpu_wr_data;
  logic                     cpu_wr_ready;
  logic                     vid_rd_req;
  logic [VGACON_ADDR_W-1:0] vid_rd_addr;
  logic                     vid_rd_valid;
  logic [7:0]               vid_rd_data;
  logic                     clear_start;
  logic                     clear_busy;
  logic                     clear_done;
  logic                     mem_we;
  logic [VGACON_ADDR_W-1:0] mem_addr;
  logic [7:0]               mem_wdata;
  logic [7:0]               mem_rdata;

  modport master (
    output cpu_wr_valid, cpu_wr_addr, cpu_wr_data, vid_rd_req, vid_rd_addr,
           clear_start, mem_rdata,
    input  cpu_wr_ready, vid_rd_valid, vid_rd_data, clear_busy, clear_done,
           mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  cpu_wr_valid, cpu_wr_addr, cpu_wr_data, vid_rd_req, vid_rd_addr,
           clear_start, mem_rdata,
    output cpu_wr_ready, vid_rd_valid, vid_rd_data, clear_busy, clear_done,
           mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/vgacon_clear_seq.sv
// Clear sequencer: walks clr_ptr over the buffer writing FILL, yielding to video reads.
module vgacon_clear_seq
  import vgacon_pkg::*;
#(
  parameter int DEPTH = VGACON_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear_start,
  input  logic                     vid_rd_req,
  output logic                     clear_busy,
  output logic                     clear_done,
  output logic                     clr_we,
  output logic [VGACON_ADDR_W-1:0] clr_ptr
);

  clr_state_e               state, state_nxt;
  logic [VGACON_ADDR_W-1:0] ptr_nxt;
  logic                     done_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      clr_ptr    <= '0;
      clear_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      clr_ptr    <= ptr_nxt;
      clear_done <= done_nxt;
    end
  end

  // A video read steals the cycle, so the pointer simply holds until the port is free.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = clr_ptr;
    done_nxt  = 1'b0;
    clr_we    = 1'b0;
    case (state)
      IDLE: begin
        if (clear_start) begin
          state_nxt = CLEAR;
          ptr_nxt   = '0;
        end
      end
      CLEAR: begin
        if (!vid_rd_req) begin
          clr_we = 1'b1;
          if (32'(clr_ptr) == DEPTH - 1) begin
            state_nxt = IDLE;
            ptr_nxt   = '0;
            done_nxt  = 1'b1;
          end else begin
            ptr_nxt = clr_ptr + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign clear_busy = (state == CLEAR);

endmodule

// File: rtl/vgacon_buffer_arbiter.sv
// Arbitrates the shared character buffer: video read > clear write > CPU write.
// Define VGACON_CLEAR_EN to build the hardware clear sequencer.
module vgacon_buffer_arbiter
  import vgacon_pkg::*;
#(
  parameter int         DEPTH = VGACON_DEPTH,
  parameter logic [7:0] FILL  = VGACON_FILL
) (
  input logic                    clk,
  input logic                    rst_n,
  vgacon_buffer_arbiter_if.slave bus
);

  logic                     clear_busy;
  logic                     clear_done;
  logic                     clr_we;
  logic [VGACON_ADDR_W-1:0] clr_ptr;
  logic                     rd_in_range;
  logic                     wr_in_range;
  logic                     rd_valid_q;
  logic                     rd_hit_q;

`ifdef VGACON_CLEAR_EN
  vgacon_clear_seq #(
    .DEPTH (DEPTH)
  ) u_clear_seq (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_start (bus.clear_start),
    .vid_rd_req  (bus.vid_rd_req),
    .clear_busy  (clear_busy),
    .clear_done  (clear_done),
    .clr_we      (clr_we),
    .clr_ptr     (clr_ptr)
  );
`else
  logic unused_clear_start;
  assign unused_clear_start = bus.clear_start;
  assign clear_busy = 1'b0;
  assign clear_done = 1'b0;
  assign clr_we     = 1'b0;
  assign clr_ptr    = '0;
`endif

  assign rd_in_range = 32'(bus.vid_rd_addr) < DEPTH;
  assign wr_in_range = 32'(bus.cpu_wr_addr) < DEPTH;

  // rd_hit_q remembers whether the memory was really read, so out-of-range reads return zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_hit_q   <= 1'b0;
    end else begin
      rd_valid_q <= bus.vid_rd_req;
      rd_hit_q   <= bus.vid_rd_req & rd_in_range;
    end
  end

  always_comb begin
    bus.mem_we       = 1'b0;
    bus.mem_addr     = '0;
    bus.mem_wdata    = '0;
    bus.cpu_wr_ready = 1'b0;
    if (rst_n) begin
      if (bus.vid_rd_req) begin
        if (rd_in_range) begin
          bus.mem_addr = bus.vid_rd_addr;
        end
      end else if (clr_we) begin
        bus.mem_we    = 1'b1;
        bus.mem_addr  = clr_ptr;
        bus.mem_wdata = FILL;
      end else if (bus.cpu_wr_valid && !clear_busy) begin
        bus.cpu_wr_ready = 1'b1;
        if (wr_in_range) begin
          bus.mem_we    = 1'b1;
          bus.mem_addr  = bus.cpu_wr_addr;
          bus.mem_wdata = bus.cpu_wr_data;
        end
      end
    end
  end

  // Gating with rst_n keeps every status output quiet even before the first reset edge.
  assign bus.vid_rd_valid = rst_n & rd_valid_q;
  assign bus.vid_rd_data  = (rst_n && rd_hit_q) ? bus.mem_rdata : 8'h00;
  assign bus.clear_busy   = rst_n & clear_busy;
  assign bus.clear_done   = rst_n & clear_done;

endmodule

// File: tb/tb_vgacon_buffer_arbiter.sv
// Self-checking bench for vgacon_buffer_arbiter against a cycle-level behavioural model.
module tb_vgacon_buffer_arbiter;
  import vgacon_pkg::*;

  localparam int         DEPTH = VGACON_DEPTH;
  localparam logic [7:0] FILL  = VGACON_FILL;
`ifdef VGACON_CLEAR_EN
  localparam bit CLEAR_EN = 1'b1;
`else
  localparam bit CLEAR_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  vgacon_buffer_arbiter_if bus ();

  vgacon_buffer_arbiter #(
    .DEPTH (DEPTH),
    .FILL  (FILL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Single-port buffer with one-cycle read latency; preloaded with a pattern while in reset.
  logic [7:0] buf_mem [128];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 128; i++) buf_mem[i] <= 8'(i * 3 + 1);
    end else if (bus.mem_we) begin
      buf_mem[bus.mem_addr] <= bus.mem_wdata;
    end
    bus.mem_rdata <= buf_mem[bus.mem_addr];
  end

  logic [7:0] ref_mem [128];
  bit         m_clearing;
  int         m_next_cell;
  bit         m_done_due;
  bit         m_rd_due;
  logic [7:0] m_rd_byte;

  bit         e_ready, e_we, e_acc, e_busy, e_done, e_rd_valid;
  logic [6:0] e_addr;
  logic [7:0] e_wdata, e_rd_data;

  task automatic model_reset();
    for (int i = 0; i < 128; i++) ref_mem[i] = 8'(i * 3 + 1);
    m_clearing  = 1'b0;
    m_next_cell = 0;
    m_done_due  = 1'b0;
    m_rd_due    = 1'b0;
    m_rd_byte   = 8'h00;
  endtask

  task automatic drive_idle();
    bus.cpu_wr_valid = 1'b0;
    bus.cpu_wr_addr  = '0;
    bus.cpu_wr_data  = '0;
    bus.vid_rd_req   = 1'b0;
    bus.vid_rd_addr  = '0;
    bus.clear_start  = 1'b0;
  endtask

  // Drives one cycle and computes what the arbiter must show during it.
  task automatic cycle(input bit cpu_v, input logic [6:0] cpu_a, input logic [7:0] cpu_d,
                       input bit rd, input logic [6:0] rd_a, input bit clr);
    bit was_clearing;
    @(negedge clk);
    bus.cpu_wr_valid = cpu_v;
    bus.cpu_wr_addr  = cpu_a;
    bus.cpu_wr_data  = cpu_d;
    bus.vid_rd_req   = rd;
    bus.vid_rd_addr  = rd_a;
    bus.clear_start  = clr;
    #1;
    e_rd_valid = m_rd_due;
    e_rd_data  = m_rd_due ? m_rd_byte : 8'h00;
    e_busy     = m_clearing;
    e_done     = m_done_due;
    e_ready = 1'b0; e_we = 1'b0; e_acc = 1'b0; e_addr = '0; e_wdata = '0;
    was_clearing = m_clearing;
    m_done_due   = 1'b0;
    m_rd_due     = rd;
    m_rd_byte    = 8'h00;
    if (rd) begin
      if (int'(rd_a) < DEPTH) begin
        e_acc     = 1'b1;
        e_addr    = rd_a;
        m_rd_byte = ref_mem[rd_a];
      end
    end else if (m_clearing) begin
      e_acc = 1'b1; e_we = 1'b1; e_addr = 7'(m_next_cell); e_wdata = FILL;
      ref_mem[m_next_cell] = FILL;
      m_next_cell++;
      if (m_next_cell == DEPTH) begin
        m_clearing = 1'b0;
        m_done_due = 1'b1;
      end
    end else if (cpu_v) begin
      e_ready = 1'b1;
      if (int'(cpu_a) < DEPTH) begin
        e_acc = 1'b1; e_we = 1'b1; e_addr = cpu_a; e_wdata = cpu_d;
        ref_mem[cpu_a] = cpu_d;
      end
    end
    if (CLEAR_EN && clr && !was_clearing) begin
      m_clearing  = 1'b1;
      m_next_cell = 0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.cpu_wr_valid = 1'b1; bus.cpu_wr_addr = 7'd4; bus.cpu_wr_data = 8'h11;
    bus.vid_rd_req = 1'b1; bus.vid_rd_addr = 7'd4; bus.clear_start = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (bus.cpu_wr_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b want 0", bus.cpu_wr_ready); end
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_we: got %b want 0", bus.mem_we); end
    checks++; if (bus.vid_rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_valid: got %b want 0", bus.vid_rd_valid); end
    checks++; if (bus.vid_rd_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_rd_data: got %h want 00", bus.vid_rd_data); end
    checks++; if (bus.clear_busy !== 1'b0 || bus.clear_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_clear: busy %b done %b want 0 0", bus.clear_busy, bus.clear_done); end
    drive_idle();
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_cpu_write();
    cycle(1'b1, 7'd5, 8'h41, 1'b0, 7'd0, 1'b0);
    checks++; if (bus.cpu_wr_ready !== 1'b1 || bus.mem_we !== 1'b1) begin errors++; $display("[TB] FAIL cpu_write_handshake: ready %b we %b want 1 1", bus.cpu_wr_ready, bus.mem_we); end
    checks++; if (bus.mem_addr !== 7'd5 || bus.mem_wdata !== 8'h41) begin errors++; $display("[TB] FAIL cpu_write_bus: addr %0d data %h want 5 41", bus.mem_addr, bus.mem_wdata); end
    cycle(1'b0, 7'd0, 8'h00, 1'b1, 7'd5, 1'b0);
    checks++; if (bus.mem_we !== 1'b0 || bus.mem_addr !== 7'd5) begin errors++; $display("[TB] FAIL read_access: we %b addr %0d want 0 5", bus.mem_we, bus.mem_addr); end
    cycle(1'b0, 7'd0, 8'h00, 1'b0, 7'd0, 1'b0);
    checks++; if (bus.vid_rd_valid !== 1'b1 || bus.vid_rd_data !== 8'h41) begin errors++; $display("[TB] FAIL readback: valid %b data %h want 1 41", bus.vid_rd_valid, bus.vid_rd_data); end
  endtask

  task automatic test_read_stall();
    for (int i = 0; i < 5; i++) begin
      cycle(i < 4, 7'd20, 8'h5A, i < 3, 7'($urandom_range(0, DEPTH - 1)), 1'b0);
      checks++;
      if (i < 4 && bus.cpu_wr_ready !== (i == 3)) begin errors++; $display("[TB] FAIL stall_ready[%0d]: got %b want %b", i, bus.cpu_wr_ready, i == 3); end
      checks++;
      if (bus.vid_rd_valid !== e_rd_valid || (e_rd_valid && bus.vid_rd_data !== e_rd_data)) begin
        errors++; $display("[TB] FAIL stall_read[%0d]: valid %b data %h want %b %h", i, bus.vid_rd_valid, bus.vid_rd_data, e_rd_valid, e_rd_data);
      end
    end
  endtask

  task automatic test_out_of_range();
    cycle(1'b0, 7'd0, 8'h00, 1'b1, 7'd100, 1'b0);
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("[TB] FAIL oor_read_we: got %b want 0", bus.mem_we); end
    cycle(1'b1, 7'd110, 8'hAB, 1'b0, 7'd0, 1'b0);
    checks++; if (bus.vid_rd_valid !== 1'b1 || bus.vid_rd_data !== 8'h00) begin errors++; $display("[TB] FAIL oor_read_data: valid %b data %h want 1 00", bus.vid_rd_valid, bus.vid_rd_data); end
    checks++; if (bus.cpu_wr_ready !== 1'b1 || bus.mem_we !== 1'b0) begin errors++; $display("[TB] FAIL oor_write: ready %b we %b want 1 0", bus.cpu_wr_ready, bus.mem_we); end
  endtask

  task automatic test_random_traffic();
    bit         cv = 1'b0;
    logic [6:0] ca = '0;
    logic [7:0] cd = '0;
    for (int i = 0; i < 300; i++) begin
      if (!cv) begin
        cv = ($urandom_range(0, 3) != 0);
        ca = 7'($urandom_range(0, 127));
        cd = 8'($urandom);
      end
      cycle(cv, ca, cd, $urandom_range(0, 2) == 0, 7'($urandom_range(0, 127)), 1'b0);
      checks++;
      if (bus.cpu_wr_ready !== e_ready || bus.mem_we !== e_we) begin
        errors++; $display("[TB] FAIL rand_arb[%0d]: ready %b we %b want %b %b", i, bus.cpu_wr_ready, bus.mem_we, e_ready, e_we);
      end
      checks++;
      if (e_acc && (bus.mem_addr !== e_addr || (e_we && bus.mem_wdata !== e_wdata))) begin
        errors++; $display("[TB] FAIL rand_bus[%0d]: addr %0d data %h want %0d %h", i, bus.mem_addr, bus.mem_wdata, e_addr, e_wdata);
      end
      checks++;
      if (bus.vid_rd_valid !== e_rd_valid || (e_rd_valid && bus.vid_rd_data !== e_rd_data)) begin
        errors++; $display("[TB] FAIL rand_read[%0d]: valid %b data %h want %b %h", i, bus.vid_rd_valid, bus.vid_rd_data, e_rd_valid, e_rd_data);
      end
      if (e_ready) cv = 1'b0;
    end
  endtask

`ifdef VGACON_CLEAR_EN
  task automatic test_clear_uncontended();
    int busy_n = 0;
    int done_n = 0;
    cycle(1'b1, 7'd3, 8'h77, 1'b0, 7'd0, 1'b1);
    checks++; if (bus.cpu_wr_ready !== 1'b1 || bus.mem_addr !== 7'd3) begin errors++; $display("[TB] FAIL clear_coincide: ready %b addr %0d want 1 3", bus.cpu_wr_ready, bus.mem_addr); end
    for (int i = 0; i < 100; i++) begin
      cycle(1'b0, 7'd0, 8'h00, 1'b0, 7'd0, i == 50);
      if (bus.clear_busy === 1'b1) busy_n++;
      if (bus.clear_done === 1'b1) done_n++;
      checks++;
      if (bus.clear_busy !== e_busy || bus.clear_done !== e_done || bus.mem_we !== e_we || (e_we && bus.mem_addr !== e_addr)) begin
        errors++; $display("[TB] FAIL clear_step[%0d]: busy %b done %b we %b addr %0d want %b %b %b %0d", i, bus.clear_busy, bus.clear_done, bus.mem_we, bus.mem_addr, e_busy, e_done, e_we, e_addr);
      end
    end
    checks++; if (busy_n != DEPTH) begin errors++; $display("[TB] FAIL clear_length: got %0d want %0d", busy_n, DEPTH); end
    checks++; if (done_n != 1) begin errors++; $display("[TB] FAIL clear_done_count: got %0d want 1", done_n); end
    @(posedge clk); #1;
    for (int c = 0; c < DEPTH; c++) begin
      checks++; if (buf_mem[c] !== FILL) begin errors++; $display("[TB] FAIL clear_cell[%0d]: got %h want %h", c, buf_mem[c], FILL); end
    end
  endtask

  task automatic test_clear_contended();
    int  busy_n = 0;
    int  reads_n = 0;
    bit  ended = 1'b0;
    cycle(1'b0, 7'd0, 8'h00, 1'b0, 7'd0, 1'b1);
    for (int i = 0; i < 400 && !ended; i++) begin
      cycle(1'b1, 7'd9, 8'h99, i[0] == 1'b0, 7'($urandom_range(0, DEPTH - 1)), 1'b0);
      if (bus.clear_busy === 1'b1) begin
        busy_n++;
        if (i[0] == 1'b0) reads_n++;
      end
      checks++;
      if (bus.clear_busy !== e_busy || bus.cpu_wr_ready !== e_ready || bus.mem_we !== e_we) begin
        errors++; $display("[TB] FAIL contend_step[%0d]: busy %b ready %b we %b want %b %b %b", i, bus.clear_busy, bus.cpu_wr_ready, bus.mem_we, e_busy, e_ready, e_we);
      end
      checks++;
      if (bus.vid_rd_valid !== e_rd_valid || (e_rd_valid && bus.vid_rd_data !== e_rd_data)) begin
        errors++; $display("[TB] FAIL contend_read[%0d]: valid %b data %h want %b %h", i, bus.vid_rd_valid, bus.vid_rd_data, e_rd_valid, e_rd_data);
      end
      if (!e_busy) ended = 1'b1;
    end
    checks++; if (!ended) begin errors++; $display("[TB] FAIL contend_timeout: clear still running want finished"); end
    checks++; if (busy_n != DEPTH + reads_n) begin errors++; $display("[TB] FAIL contend_length: got %0d want %0d", busy_n, DEPTH + reads_n); end
    cycle(1'b0, 7'd0, 8'h00, 1'b0, 7'd0, 1'b0);
    @(posedge clk); #1;
    for (int c = 0; c < DEPTH; c++) begin
      checks++; if (buf_mem[c] !== ref_mem[c]) begin errors++; $display("[TB] FAIL contend_cell[%0d]: got %h want %h", c, buf_mem[c], ref_mem[c]); end
    end
  endtask

  task automatic test_clear_reset();
    cycle(1'b0, 7'd0, 8'h00, 1'b0, 7'd0, 1'b1);
    for (int i = 0; i < 40; i++) cycle(1'b0, 7'd0, 8'h00, 1'b0, 7'd0, 1'b0);
    checks++; if (bus.clear_busy !== 1'b1 || bus.mem_addr !== 7'd39) begin errors++; $display("[TB] FAIL abort_setup: busy %b addr %0d want 1 39", bus.clear_busy, bus.mem_addr); end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk); #1;
    checks++; if (bus.clear_busy !== 1'b0 || bus.clear_done !== 1'b0) begin errors++; $display("[TB] FAIL abort_reset: busy %b done %b want 0 0", bus.clear_busy, bus.clear_done); end
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 7'd0, 8'h00, 1'b0, 7'd0, 1'b0);
      checks++;
      if (bus.clear_busy !== 1'b0 || bus.clear_done !== 1'b0 || bus.mem_we !== 1'b0) begin
        errors++; $display("[TB] FAIL abort_after[%0d]: busy %b done %b we %b want 0 0 0", i, bus.clear_busy, bus.clear_done, bus.mem_we);
      end
    end
  endtask
`else
  task automatic test_clear_disabled();
    cycle(1'b1, 7'd12, 8'h33, 1'b0, 7'd0, 1'b1);
    checks++; if (bus.cpu_wr_ready !== 1'b1 || bus.mem_we !== 1'b1) begin errors++; $display("[TB] FAIL nclear_write: ready %b we %b want 1 1", bus.cpu_wr_ready, bus.mem_we); end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 7'd13, 8'h34, 1'b0, 7'd0, 1'b0);
      checks++;
      if (bus.clear_busy !== 1'b0 || bus.clear_done !== 1'b0 || bus.cpu_wr_ready !== 1'b1) begin
        errors++; $display("[TB] FAIL nclear_idle[%0d]: busy %b done %b ready %b want 0 0 1", i, bus.clear_busy, bus.clear_done, bus.cpu_wr_ready);
      end
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    drive_idle();
    model_reset();
    test_reset();
    test_cpu_write();
    test_read_stall();
    test_out_of_range();
    test_random_traffic();
`ifdef VGACON_CLEAR_EN
    test_clear_uncontended();
    test_clear_contended();
    test_clear_reset();
`else
    test_clear_disabled();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vgacon_buffer_arbiter.md
VGACON_BUFFER_ARBITER -- requirements
Module: vgacon_buffer_arbiter

Interface
REQ-001 Parameter DEPTH, default 96, SHALL set the number of character cells in the shared buffer.
REQ-002 Parameter FILL, default 8'h20, SHALL set the byte written by a hardware clear.
REQ-003 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 cpu_wr_valid  input  1  CPU write request; held until accepted.
REQ-006 cpu_wr_addr  input  7  CPU cell address.
REQ-007 cpu_wr_data  input  8  CPU character byte.
REQ-008 cpu_wr_ready  output  1  write accepted this cycle.
REQ-009 vid_rd_req  input  1  scan-out read request, single cycle.
REQ-010 vid_rd_addr  input  7  scan-out cell address.
REQ-011 vid_rd_valid  output  1  read data valid.
REQ-012 vid_rd_data  output  8  read character byte.
REQ-013 clear_start  input  1  pulse that starts a full-buffer clear.
REQ-014 clear_busy  output  1  clear in progress.
REQ-015 clear_done  output  1  one-cycle pulse after the last clear write.
REQ-016 mem_we, mem_addr[6:0], mem_wdata[7:0]  outputs  single-port buffer control.
REQ-017 mem_rdata  input  8  buffer read data, valid one cycle after the address is presented.

Function
REQ-018 The block SHALL drive at most one buffer access per cycle, with fixed priority: video read, then clear write, then CPU write.
REQ-019 A vid_rd_req in cycle N SHALL always be granted; vid_rd_valid SHALL be high in N+1 with vid_rd_data = mem_rdata.
REQ-020 If vid_rd_addr >= DEPTH, the block SHALL issue no access and SHALL return vid_rd_data = 8'h00 with vid_rd_valid in N+1.
REQ-021 cpu_wr_ready SHALL be combinational and high only when cpu_wr_valid is high, vid_rd_req is low and the FSM is not in CLEAR; mem_we is high in the same cycle.
REQ-022 A CPU write with cpu_wr_addr >= DEPTH SHALL be accepted (ready high) but SHALL NOT assert mem_we.
REQ-023 The FSM SHALL have states IDLE and CLEAR, and a pointer clr_ptr of 7 bits.
REQ-024 In IDLE, a clear_start SHALL move the FSM to CLEAR with clr_ptr = 0 in the next cycle.
REQ-025 In CLEAR, in each cycle without vid_rd_req, the block SHALL write FILL at clr_ptr and increment clr_ptr; a cycle with vid_rd_req SHALL hold clr_ptr.
REQ-026 After the write at DEPTH-1, the FSM SHALL return to IDLE, and clear_done SHALL pulse in the following cycle.
REQ-027 clear_busy SHALL equal (state == CLEAR).
REQ-028 A clear_start while in CLEAR SHALL be ignored.
REQ-029 If clear_start and cpu_wr_valid coincide in IDLE, the CPU write SHALL complete that cycle and the clear SHALL start in the next cycle, overwriting it.
REQ-030 An uncontended clear SHALL take exactly DEPTH cycles from entry into CLEAR to return to IDLE.

Reset
REQ-031 While rst_n is low: state = IDLE, clr_ptr = 0, and cpu_wr_ready, vid_rd_valid, clear_busy, clear_done and mem_we all = 0; vid_rd_data = 8'h00.
REQ-032 A reset during CLEAR SHALL abort the clear with no clear_done pulse; buffer contents are then unspecified.

Configuration
REQ-033 With VGACON_CLEAR_EN defined, the clear sequencer SHALL be built as specified above.
REQ-034 Without VGACON_CLEAR_EN, clear_start SHALL be ignored, clear_busy and clear_done SHALL be tied to 0, and the arbitration is video-over-CPU only.

Structure
REQ-035 The shared package vgacon_pkg SHALL hold VGACON_DEPTH, VGACON_ADDR_W, VGACON_FILL and the FSM state enum.
REQ-036 The clear FSM and clr_ptr SHALL live in the sub-module vgacon_clear_seq, instantiated only under VGACON_CLEAR_EN.

Verification
REQ-037 CPU write addr 5 data 0x41, no video read -> ready high in the same cycle, with mem_we=1, mem_addr=5, mem_wdata=0x41.
REQ-038 CPU write held while vid_rd_req is high for 3 cycles -> ready stays low for 3 cycles and rises in cycle 4; reads return their data one cycle after each request.
REQ-039 vid_rd_addr 100 -> no access is issued, and vid_rd_valid=1 with data 0x00 next cycle.
REQ-040 clear_start, no contention -> busy for 96 cycles, all cells = 0x20, and a single clear_done pulse.
REQ-041 clear_start plus video reads every other cycle -> clear completes in 96 + (number of reads) cycles with no missed cell, and CPU writes stall throughout.
REQ-042 Reset asserted at clr_ptr=40 -> IDLE next cycle, busy=0, no clear_done.
